// File: rtl/note_pkg.sv
// Shared constants, boundary table and FSM states for the note mapper.
package note_pkg;

  localparam int NUM_NOTES = 48;
  localparam logic [5:0] NOTE_NONE = 6'd63;

  // Lower edge of each note, C2..B5, plus the upper edge of B5
  localparam logic [10:0] BOUND [0:48] = '{
    11'd64,  11'd67,  11'd71,  11'd76,
    11'd80,  11'd85,  11'd90,  11'd95,
    11'd101, 11'd107, 11'd113, 11'd120,
    11'd127, 11'd135, 11'd143, 11'd151,
    11'd160, 11'd170, 11'd180, 11'd190,
    11'd202, 11'd214, 11'd226, 11'd240,
    11'd254, 11'd269, 11'd285, 11'd302,
    11'd320, 11'd339, 11'd359, 11'd381,
    11'd403, 11'd427, 11'd453, 11'd480,
    11'd508, 11'd539, 11'd571, 11'd605,
    11'd640, 11'd679, 11'd719, 11'd762,
    11'd807, 11'd855, 11'd906, 11'd960,
    11'd1017
  };

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    REPORT
  } state_t;

endpackage

// File: rtl/note_bound_rom.sv
// Combinational index to note-boundary lookup.
module note_bound_rom
  import note_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [10:0] bound
);

  always_comb begin
    bound = 11'h7ff;
    if (idx <= 6'(NUM_NOTES))
      bound = BOUND[idx];
  end

endmodule

// File: rtl/note_mapper.sv
// Maps decoded peak frequency to a chromatic note index by sequential search.
// Stability run counter is built only when NOTE_STABLE_EN is defined.
module note_mapper
  import note_pkg::*;
#(
  parameter int FREQ_W     = 17,
  parameter int STABLE_CNT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FREQ_W-1:0] frequency,
  input  logic              note_dec,
  output logic [5:0]        note_idx,
  output logic              note_valid,
  output logic              out_of_range,
  output logic              note_stable,
  output logic              busy
);

  state_t            state;
  logic              note_dec_q;
  logic [FREQ_W-1:0] freq_q;
  logic [5:0]        idx;
  logic [10:0]       bound;
  logic              start;
  logic              below;
  logic              done;

  note_bound_rom u_rom (
    .idx   (idx),
    .bound (bound)
  );

  assign start = note_dec & ~note_dec_q & (state == IDLE);
  assign below = freq_q < FREQ_W'(bound);
  assign done  = below | (idx == 6'(NUM_NOTES));
  assign busy  = state != IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      note_dec_q   <= 1'b0;
      freq_q       <= '0;
      idx          <= '0;
      note_idx     <= NOTE_NONE;
      note_valid   <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      note_dec_q <= note_dec;
      note_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            freq_q <= frequency;
            idx    <= '0;
            state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (done) begin
            state      <= REPORT;
            note_valid <= 1'b1;
            if (below && idx != 6'd0) begin
              note_idx     <= idx - 6'd1;
              out_of_range <= 1'b0;
            end else begin
              note_idx     <= NOTE_NONE;
              out_of_range <= 1'b1;
            end
          end else begin
            idx <= idx + 6'd1;
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOTE_STABLE_EN
  localparam logic [3:0] RUN_MAX = 4'(STABLE_CNT);

  logic [3:0] run;
  logic [5:0] prev_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run      <= '0;
      prev_idx <= NOTE_NONE;
    end else if (state == REPORT) begin
      if (note_idx == prev_idx && note_idx != NOTE_NONE) begin
        if (run < RUN_MAX)
          run <= run + 4'd1;
      end else begin
        run      <= (note_idx == NOTE_NONE) ? 4'd0 : 4'd1;
        prev_idx <= note_idx;
      end
    end
  end

  assign note_stable = run >= RUN_MAX;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      note_stable <= 1'b0;
    else if (state == REPORT)
      note_stable <= note_idx != NOTE_NONE;
  end
`endif

endmodule

// File: tb/tb_note_mapper.sv
// Randomized bench for note_mapper against a frequency-table reference model.
module tb_note_mapper;

  localparam int STABLE_CNT = 3;
  localparam int NONE = 63;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] frequency = '0;
  logic        note_dec = 1'b0;
  logic [5:0]  note_idx;
  logic        note_valid;
  logic        out_of_range;
  logic        note_stable;
  logic        busy;

  note_mapper #(
    .FREQ_W     (17),
    .STABLE_CNT (STABLE_CNT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frequency    (frequency),
    .note_dec     (note_dec),
    .note_idx     (note_idx),
    .note_valid   (note_valid),
    .out_of_range (out_of_range),
    .note_stable  (note_stable),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int bnd [49];
  int hist [$];

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int ref_note(int f);
    if (f < bnd[0] || f >= bnd[48])
      return NONE;
    for (int i = 47; i >= 0; i--)
      if (f >= bnd[i])
        return i;
    return NONE;
  endfunction

  function automatic int ref_lat(int f);
    if (f < bnd[0])
      return 1;
    if (ref_note(f) == NONE)
      return 49;
    return ref_note(f) + 2;
  endfunction

  // Stable when the most recent results form a run of one real note
  function automatic int ref_stable();
    int last;
    if (hist.size() == 0)
      return 0;
    last = hist[hist.size()-1];
    if (last == NONE)
      return 0;
`ifdef NOTE_STABLE_EN
    if (hist.size() < STABLE_CNT)
      return 0;
    for (int k = 1; k <= STABLE_CNT; k++)
      if (hist[hist.size()-k] != last)
        return 0;
    return 1;
`else
    return 1;
`endif
  endfunction

  task automatic run_one(int f);
    int  n;
    int  exp_idx;
    bit  seen;
    @(negedge clk);
    frequency = 17'(f);
    note_dec = 1'b1;
    @(posedge clk);
    #1;
    note_dec = 1'b0;
    check("busy_rise", int'(busy), 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      seen = note_valid;
    end
    exp_idx = ref_note(f);
    hist.push_back(exp_idx);
    check("latency", n, ref_lat(f));
    check("note_idx", int'(note_idx), exp_idx);
    check("oor", int'(out_of_range), int'(exp_idx == NONE));
    @(posedge clk);
    #1;
    check("valid_pulse", int'(note_valid), 0);
    check("busy_fall", int'(busy), 0);
    check("stable", int'(note_stable), ref_stable());
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_idx"}, int'(note_idx), NONE);
    check({tag, "_valid"}, int'(note_valid), 0);
    check({tag, "_oor"}, int'(out_of_range), 0);
    check({tag, "_stable"}, int'(note_stable), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int nv;
    int at;
    int seen_idx;
    int dir [11];

    for (int i = 0; i < 49; i++)
      bnd[i] = int'($floor(65.406 * (2.0 ** (i / 12.0))
               * (2.0 ** (-1.0 / 24.0)) + 0.5));

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;

    dir = '{440, 440, 440, 468, 30, 453, 452, 2000, 64, 1016, 1017};
    foreach (dir[k])
      run_one(dir[k]);
    run_one(63);
    run_one(0);

    // Long level plus a second edge during SEARCH
    @(negedge clk);
    frequency = 17'd440;
    note_dec = 1'b1;
    nv = 0;
    at = -1;
    seen_idx = -1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (c == 10) note_dec = 1'b0;
      if (c == 11) note_dec = 1'b1;
      if (note_valid) begin
        nv++;
        at = c;
        seen_idx = int'(note_idx);
      end
    end
    note_dec = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (note_valid) nv++;
    end
    hist.push_back(33);
    check("hold_count", nv, 1);
    check("hold_lat", at, 35);
    check("hold_idx", seen_idx, 33);
    check("hold_stable", int'(note_stable), ref_stable());

    // Reset mid-search after building a stable run
    run_one(440);
    run_one(441);
    run_one(445);
    @(negedge clk);
    frequency = 17'd440;
    note_dec = 1'b1;
    @(posedge clk);
    #1;
    note_dec = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    nv = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (note_valid) nv++;
    end
    check("midrst_novalid", nv, 0);
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    run_one(440);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0)
        run_one(440 + int'($urandom_range(0, 12)));
      else
        run_one(int'($urandom_range(0, 1100)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
